key_input: RTL and testbench

- Input-side counterpart to the LED output path: conditions raw active-low push-button inputs on the board into clean, single-cycle events for the fabric.
- Each key is synchronized, debounced by a per-key state machine, and edge-detected.
- A press counter on key 0 produces a 10-bit value that can drive the LED bank directly.

---
 rtl/key_input.sv | 126 ++++++++++++
 tb/tb_key_input.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/key_input.sv
// key_input: conditions raw active-low push buttons into clean single-cycle
// press/release events. Each key is double-flop synchronized, debounced by
// its own four-state machine and edge-detected; key 0 also drives a 10-bit
// press counter suitable for the LED bank.
module key_input #(
    parameter  int N_KEYS          = 4,
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] KEY_N,
    input  logic              CNT_CLR,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [9:0]        PRESS_CNT
);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        WAIT_DN = 2'd1,
        DN      = 2'd2,
        WAIT_UP = 2'd3
    } key_state_t;

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] key_s;
    key_state_t        state [N_KEYS];
    logic [DB_W-1:0]   cnt   [N_KEYS];

    // Two-flop synchronizer; resets to the released (high) pin level.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY_N;
            sync2 <= sync1;
        end
    end

    // Synced key value, active-high pressed.
    assign key_s = ~sync2;

    // Per-key debounce FSMs with registered level and one-cycle event pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the per-key state/counter arrays are control registers, so they are reset like any other flop.
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= UP;
                cnt[i]   <= '0;
            end
            KEY_LEVEL   <= '0;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
        end else begin
            // Pulses default low and are raised only on an accepting edge.
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                case (state[i])
                    UP: begin
                        if (key_s[i]) begin
                            state[i] <= WAIT_DN;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    WAIT_DN: begin
                        if (!key_s[i]) begin
                            state[i] <= UP;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]     <= DN;
                            cnt[i]       <= '0;
                            KEY_LEVEL[i] <= 1'b1;
                            KEY_PRESS[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    DN: begin
                        if (!key_s[i]) begin
                            state[i] <= WAIT_UP;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    WAIT_UP: begin
                        if (key_s[i]) begin
                            state[i] <= DN;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= UP;
                            cnt[i]         <= '0;
                            KEY_LEVEL[i]   <= 1'b0;
                            KEY_RELEASE[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= UP;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Key-0 press counter; a clear coinciding with a press keeps that press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PRESS_CNT <= '0;
        end else if (CNT_CLR) begin
            PRESS_CNT <= {9'd0, KEY_PRESS[0]};
        end else if (KEY_PRESS[0]) begin
            PRESS_CNT <= PRESS_CNT + 10'd1;
        end
    end

endmodule

// File: tb/tb_key_input.sv
// Testbench for key_input with N_KEYS=4, DEBOUNCE_CYCLES=4. Expected pulse
// events (cycle, press vector, release vector) are queued when a key pin is
// driven and compared when the DUT pulses.
module tb_key_input;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int LAT = DB + 2;

    logic          CLK;
    logic          RST;
    logic [NK-1:0] KEY_N;
    logic          CNT_CLR;
    logic [NK-1:0] KEY_LEVEL;
    logic [NK-1:0] KEY_PRESS;
    logic [NK-1:0] KEY_RELEASE;
    logic [9:0]    PRESS_CNT;

    typedef struct {
        int            cyc;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } ev_t;

    ev_t sb[$];
    ev_t ev;
    int  cyc;
    int  n_cmp;
    int  n_err;

    key_input #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .KEY_N       (KEY_N),
        .CNT_CLR     (CNT_CLR),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE),
        .PRESS_CNT   (PRESS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r);
        ev_t e;
        e.cyc = c;
        e.prs = p;
        e.rel = r;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: sample outputs on the falling edge.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_pulse_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if ((KEY_PRESS | KEY_RELEASE) != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {KEY_PRESS, KEY_RELEASE}, 0);
            end else begin
                ev = sb.pop_front();
                check("pulse_cycle", cyc, ev.cyc);
                check("pulse_press", KEY_PRESS, ev.prs);
                check("pulse_release", KEY_RELEASE, ev.rel);
            end
        end
    end

    initial begin
        cyc     = 0;
        n_cmp   = 0;
        n_err   = 0;
        RST     = 1'b1;
        KEY_N   = '1;
        CNT_CLR = 1'b0;

        // Reset state
        tick(3);
        check("rst_level", KEY_LEVEL, 0);
        check("rst_press", KEY_PRESS, 0);
        check("rst_release", KEY_RELEASE, 0);
        check("rst_cnt", PRESS_CNT, 0);
        RST = 1'b0;
        tick(2);

        // Clean press and release on key 0
        KEY_N[0] = 1'b0;
        push(cyc + LAT, 4'b0001, 4'b0000);
        tick(LAT);
        check("clean_level_on", KEY_LEVEL, 4'b0001);
        tick(1);
        check("clean_cnt", PRESS_CNT, 1);
        tick(13);
        KEY_N[0] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0001);
        tick(LAT - 1);
        check("clean_level_hold", KEY_LEVEL, 4'b0001);
        tick(1);
        check("clean_level_off", KEY_LEVEL, 4'b0000);
        tick(2);

        // Bounce rejection on key 1
        KEY_N[1] = 1'b0; tick(3);
        KEY_N[1] = 1'b1; tick(1);
        KEY_N[1] = 1'b0; tick(2);
        KEY_N[1] = 1'b1; tick(1);
        KEY_N[1] = 1'b0;
        push(cyc + LAT, 4'b0010, 4'b0000);
        tick(LAT - 1);
        check("bounce_level_low", KEY_LEVEL, 4'b0000);
        tick(1);
        check("bounce_level_high", KEY_LEVEL, 4'b0010);
        KEY_N[1] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0010);
        tick(LAT + 2);

        // Counter clear alone, then wrap
        CNT_CLR = 1'b1;
        tick(1);
        CNT_CLR = 1'b0;
        check("clr_alone", PRESS_CNT, 0);
        for (int i = 1; i <= 1025; i++) begin
            KEY_N[0] = 1'b0;
            push(cyc + LAT, 4'b0001, 4'b0000);
            tick(LAT + 1);
            if (i >= 1023) check("wrap_cnt", PRESS_CNT, i % 1024);
            KEY_N[0] = 1'b1;
            push(cyc + LAT, 4'b0000, 4'b0001);
            tick(LAT + 1);
        end
        check("wrap_final", PRESS_CNT, 1);

        // Clear coincident with a press keeps the press
        KEY_N[0] = 1'b0;
        push(cyc + LAT, 4'b0001, 4'b0000);
        tick(LAT);
        CNT_CLR = 1'b1;
        tick(1);
        CNT_CLR = 1'b0;
        check("clr_with_press", PRESS_CNT, 1);
        KEY_N[0] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0001);
        tick(LAT + 2);

        // All keys at once
        KEY_N = 4'b0000;
        push(cyc + LAT, 4'b1111, 4'b0000);
        tick(LAT);
        check("simul_level", KEY_LEVEL, 4'b1111);
        tick(1);
        check("simul_cnt", PRESS_CNT, 2);
        KEY_N = 4'b1111;
        push(cyc + LAT, 4'b0000, 4'b1111);
        tick(LAT + 2);

        // Asynchronous reset during key-2 debounce
        KEY_N[0] = 1'b0;
        push(cyc + LAT, 4'b0001, 4'b0000);
        tick(LAT + 2);
        KEY_N[2] = 1'b0;
        tick(4);
        #3;
        RST      = 1'b1;
        KEY_N[0] = 1'b1;
        #1;
        check("amid_rst_level", KEY_LEVEL, 0);
        check("amid_rst_press", KEY_PRESS, 0);
        check("amid_rst_release", KEY_RELEASE, 0);
        check("amid_rst_cnt", PRESS_CNT, 0);
        tick(1);
        RST = 1'b0;
        push(cyc + LAT, 4'b0100, 4'b0000);
        tick(LAT);
        check("post_rst_level", KEY_LEVEL, 4'b0100);
        KEY_N[2] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b0100);
        tick(LAT + 2);

        // Held key: single press, no auto-repeat
        KEY_N[3] = 1'b0;
        push(cyc + LAT, 4'b1000, 4'b0000);
        tick(1000);
        check("held_level", KEY_LEVEL, 4'b1000);
        KEY_N[3] = 1'b1;
        push(cyc + LAT, 4'b0000, 4'b1000);
        tick(LAT + 3);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
